line_window_3x3: RTL
====================

LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

Interface
REQ-001 SHALL have parameter IMG_W, default 28, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28, image height in pixels.
REQ-003 SHALL have parameter DW, default 8, pixel width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port pixel  input  DW  raster-order pixel from upstream pixel feeder.
REQ-007 SHALL have port valid  input  1  pixel qualifier; pixel accepted on every rising edge with valid=1.
REQ-008 SHALL have port win  output  9*DW  3x3 window; element (r,c) at bits [(r*3+c)*DW +: DW], r=0 oldest row, c=0 leftmost column.
REQ-009 SHALL have port win_valid  output  1  one-cycle qualifier for win, out_row, out_col.
REQ-010 SHALL have port out_row  output  5  top-left row of current window (0..IMG_H-3).
REQ-011 SHALL have port out_col  output  5  top-left column of current window (0..IMG_W-3).
REQ-012 SHALL have port frame_done  output  1  single-cycle pulse coincident with last window of a frame.

Function
REQ-013 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) giving the position of the next accepted pixel.
REQ-014 SHALL, on each accepted pixel, advance col; at col=IMG_W-1 wrap col to 0 and advance row; at row=IMG_H-1 and col=IMG_W-1 wrap both to 0, the next pixel starting a new frame with no idle cycle.
REQ-015 SHALL hold two line buffers of IMG_W entries each, storing the previous two image rows; on an accepted pixel, line1 entry col moves to line0 entry col and pixel is written to line1 entry col.
REQ-016 SHALL hold a 3x3 register window shifting left by one column per accepted pixel, new right column = {line0[col], line1[col], pixel} for r=0,1,2.
REQ-017 SHALL assert win_valid exactly one cycle after accepting a pixel at (row,col) with row>=2 and col>=2, with win reflecting the window whose bottom-right is that pixel.
REQ-018 SHALL drive out_row=row-2 and out_col=col-2 of that pixel, registered alongside win.
REQ-019 SHALL produce exactly (IMG_W-2)*(IMG_H-2) = 676 win_valid pulses per frame at default parameters; windows spanning a row boundary (col<2) SHALL never be flagged valid.
REQ-020 SHALL assert frame_done in the same cycle as win_valid for out_row=IMG_H-3, out_col=IMG_W-3.
REQ-021 SHALL, when valid=0, hold counters, line buffers and window unchanged and drive win_valid=0, frame_done=0 that cycle.
REQ-022 SHALL hold win, out_row, out_col stable between win_valid pulses.
REQ-023 SHALL not require line buffer contents from a previous frame to be cleared; gating by row>=2 SHALL guarantee stale data is never presented as valid.

Reset
REQ-024 SHALL, on rst=1, asynchronously clear col, row, win_valid, frame_done, out_row, out_col and win to 0.
REQ-025 SHALL treat the first accepted pixel after rst deassertion as (0,0) of a new frame, including reset asserted mid-frame.
REQ-026 SHALL leave line buffer storage unreset.

Verification
REQ-027 SHALL pass: continuous valid, pixel = index mod 256 -> first win_valid one cycle after index 58, win (r0..r2) = 0,1,2 / 28,29,30 / 56,57,58, out_row=0, out_col=0.
REQ-028 SHALL pass: one full frame continuous -> exactly 676 win_valid pulses, frame_done once with out_row=25, out_col=25, window bottom-right = 783 mod 256 = 15.
REQ-029 SHALL pass: back-to-back frames -> second frame first window one cycle after index 842, win = 16,17,18 / 44,45,46 / 72,73,74.
REQ-030 SHALL pass: valid deasserted for 5 cycles at index 100 -> no win_valid during gap, outputs held, subsequent windows identical to gap-free run.
REQ-031 SHALL pass: rst pulsed at index 400 -> outputs zero immediately, next accepted pixel treated as (0,0), first window after 59 more pixels.
REQ-032 SHALL pass: pixel at col 0 and col 1 of any row >=2 -> win_valid remains 0.

Source files
------------

// File: rtl/line_window_3x3.sv
// 3x3 sliding window over a raster pixel stream, built from two line buffers and a column shift register.
// Emits one qualified window per pixel whose 3x3 neighbourhood lies entirely inside the frame.
module line_window_3x3 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int DW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   pixel,
    input  logic            valid,
    output logic [9*DW-1:0] win,
    output logic            win_valid,
    output logic [4:0]      out_row,
    output logic [4:0]      out_col,
    output logic            frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [DW-1:0]   line0 [IMG_W];
    logic [DW-1:0]   line1 [IMG_W];
    logic [DW-1:0]   sh_p0 [3][2];
    logic [DW-1:0]   col_new [3];
    logic [9*DW-1:0] win_nxt;
    logic            last_col;
    logic            last_row;
    logic            vld_p0;

    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));
    // Only windows fully inside the current frame qualify; this also hides stale line data from a previous frame.
    assign vld_p0   = valid && (row >= RW'(2)) && (col >= CW'(2));

    always_comb begin
        col_new[0] = line0[col];
        col_new[1] = line1[col];
        col_new[2] = pixel;
        win_nxt    = '0;
        for (int r = 0; r < 3; r++) begin
            win_nxt[(r*3+0)*DW +: DW] = sh_p0[r][0];
            win_nxt[(r*3+1)*DW +: DW] = sh_p0[r][1];
            win_nxt[(r*3+2)*DW +: DW] = col_new[r];
        end
    end

    // Stage p0 -> storage: line buffers and window columns, deliberately left unreset
    always_ff @(posedge clk) begin
        if (valid) begin
            line0[col] <= line1[col];
            line1[col] <= pixel;
            for (int r = 0; r < 3; r++) begin
                sh_p0[r][0] <= sh_p0[r][1];
                sh_p0[r][1] <= col_new[r];
            end
        end
    end

    // Stage p0 -> outputs: position counters and registered window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_row    <= '0;
            out_col    <= '0;
            win        <= '0;
        end else begin
            win_valid  <= vld_p0;
            frame_done <= valid && last_row && last_col;
            if (valid) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (vld_p0) begin
                win     <= win_nxt;
                out_row <= 5'(row - RW'(2));
                out_col <= 5'(col - CW'(2));
            end
        end
    end

endmodule
